// File: rtl/carryskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor: rank 0 captures operands, stage k resolves block k into rank k+1,
// and the last stage writes the output registers (sum/cout/ovf/skip_cnt) with optional signed saturation.
module carryskip_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  input  logic                                 cin,
  input  logic [1:0]                           op,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0]                     sum,
  output logic                                 cout,
  output logic                                 ovf,
  output logic [$clog2(WIDTH/BLOCK+1)-1:0]     skip_cnt
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int CW   = $clog2(NBLK + 1);

  // Per-rank state; operand bits above the current block act as skew registers,
  // partial sum bits below it as de-skew registers.
  logic [NBLK-1:0]  v_q;
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] bp_q  [NBLK];
  logic [WIDTH-1:0] s_q   [NBLK];
  logic [CW-1:0]    cnt_q [NBLK];
  logic             c_q   [NBLK];
  logic             sat_q [NBLK];

  logic [WIDTH-1:0] blk_s   [NBLK];
  logic [CW-1:0]    blk_cnt [NBLK];
  logic             blk_c   [NBLK];
  logic             c_msb_in;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    skip_q, skip_d;

  logic stall;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    logic [BLOCK-1:0] ab, bb, pb, sb;
    logic [BLOCK:0]   rc;
    logic [WIDTH-1:0] ins;
    logic             grp_p;

    always_comb begin
      ab    = a_q[k][k*BLOCK +: BLOCK];
      bb    = bp_q[k][k*BLOCK +: BLOCK];
      pb    = ab ^ bb;
      sb    = '0;
      rc    = '0;
      rc[0] = c_q[k];
      for (int i = 0; i < BLOCK; i++) begin
        sb[i]   = pb[i] ^ rc[i];
        rc[i+1] = (ab[i] & bb[i]) | (pb[i] & rc[i]);
      end
      grp_p = &pb;
      ins   = '0;
      ins[k*BLOCK +: BLOCK] = sb;
    end

    assign blk_s[k]   = s_q[k] | ins;
    assign blk_c[k]   = grp_p ? c_q[k] : rc[BLOCK];
    assign blk_cnt[k] = cnt_q[k] + CW'(grp_p);

    if (k == NBLK - 1) begin : g_last
      assign c_msb_in = rc[BLOCK-1];
    end
  end

  always_comb begin
    cout_d = blk_c[NBLK-1];
    ovf_d  = c_msb_in ^ blk_c[NBLK-1];
    sum_d  = blk_s[NBLK-1];
    skip_d = blk_cnt[NBLK-1];
    if (sat_q[NBLK-1] && ovf_d) begin
      sum_d = a_q[NBLK-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      skip_q      <= '0;
    end else if (!stall) begin
      v_q[0]   <= in_valid;
      a_q[0]   <= a;
      bp_q[0]  <= op[0] ? ~b : b;
      c_q[0]   <= op[0] | cin;
      sat_q[0] <= op[1];
      s_q[0]   <= '0;
      cnt_q[0] <= '0;
      for (int k = 1; k < NBLK; k++) begin
        v_q[k]   <= v_q[k-1];
        a_q[k]   <= a_q[k-1];
        bp_q[k]  <= bp_q[k-1];
        c_q[k]   <= blk_c[k-1];
        sat_q[k] <= sat_q[k-1];
        s_q[k]   <= blk_s[k-1];
        cnt_q[k] <= blk_cnt[k-1];
      end
      out_valid_q <= v_q[NBLK-1];
      // Result registers only load on a real transaction so they keep the last value across bubbles.
      if (v_q[NBLK-1]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        skip_q <= skip_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_carryskip_adder_pipe.sv
// Scoreboard bench for carryskip_adder_pipe (WIDTH=16, BLOCK=4): directed vectors, back-pressure,
// mid-flight reset and a randomized flow-control run.
module tb_carryskip_adder_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic [1:0]  op;
  logic [2:0]  skip_cnt;

  carryskip_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [2:0]  skip;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [1:0]  op;
    logic [15:0] sum;
    logic        cout, ovf;
    logic [2:0]  skip;
  } vec_t;

  exp_t        sb_q[$];
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0;
  bit          lat_mode = 0;
  bit          rnd_done = 0;
  exp_t        mon_e;
  logic [15:0] last_sum, p_sum;
  logic        last_cout, last_ovf, p_cout, p_ovf;
  logic [2:0]  last_skip, p_skip;
  bit          p_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic [1:0] o);
    exp_t        e;
    logic [15:0] bp;
    logic        c0;
    logic [16:0] full;
    int          sres;
    bp   = o[0] ? ~bv : bv;
    c0   = o[0] ? 1'b1 : ci;
    full = {1'b0, av} + {1'b0, bp} + {16'd0, c0};
    if (o[0]) sres = int'($signed(av)) - int'($signed(bv));
    else      sres = int'($signed(av)) + int'($signed(bv)) + (ci ? 1 : 0);
    e.cout = full[16];
    e.ovf  = (sres > 32767) || (sres < -32768);
    e.sum  = full[15:0];
    if (o[1] && e.ovf) e.sum = av[15] ? 16'h8000 : 16'h7FFF;
    e.skip = 3'd0;
    for (int i = 0; i < 4; i++)
      if ((av[i*4 +: 4] ^ bp[i*4 +: 4]) == 4'hF) e.skip = e.skip + 3'd1;
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      p_stall = 0;
    end else begin
      check_val("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (p_stall) begin
        check_val("hold_valid", 32'(out_valid), 32'd1);
        check_val("hold_sum", 32'(sum), 32'(p_sum));
        check_val("hold_cout", 32'(cout), 32'(p_cout));
        check_val("hold_ovf", 32'(ovf), 32'(p_ovf));
        check_val("hold_skip", 32'(skip_cnt), 32'(p_skip));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("stale_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("sum", 32'(sum), 32'(mon_e.sum));
          check_val("cout", 32'(cout), 32'(mon_e.cout));
          check_val("ovf", 32'(ovf), 32'(mon_e.ovf));
          check_val("skip_cnt", 32'(skip_cnt), 32'(mon_e.skip));
          if (mon_e.lat) check_val("latency", 32'(cyc - mon_e.acc), 32'd4);
          last_sum  = sum;
          last_cout = cout;
          last_ovf  = ovf;
          last_skip = skip_cnt;
        end
      end
      p_stall = out_valid && !out_ready;
      p_sum   = sum;
      p_cout  = cout;
      p_ovf   = ovf;
      p_skip  = skip_cnt;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the transaction.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic [1:0] o);
    exp_t e;
    a = av; b = bv; cin = ci; op = o; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(av, bv, ci, o);
        e.acc = cyc + 1;
        e.lat = lat_mode;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check_val("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
    check_val("drain", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check_val("idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[12] = '{
    '{16'h1234, 16'h0FCD, 1'b0, 2'd0, 16'h2201, 1'b0, 1'b0, 3'd1},
    '{16'hFFFF, 16'h0000, 1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd4},
    '{16'h0005, 16'h0007, 1'b0, 2'd1, 16'hFFFE, 1'b0, 1'b0, 3'd3},
    '{16'h0005, 16'h0007, 1'b1, 2'd1, 16'hFFFE, 1'b0, 1'b0, 3'd3},
    '{16'h7FFF, 16'h0001, 1'b0, 2'd2, 16'h7FFF, 1'b0, 1'b1, 3'd2},
    '{16'h8000, 16'h0001, 1'b0, 2'd3, 16'h8000, 1'b1, 1'b1, 3'd2},
    '{16'h7FFF, 16'h0001, 1'b0, 2'd0, 16'h8000, 1'b0, 1'b1, 3'd2},
    '{16'h8000, 16'h8000, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 3'd4},
    '{16'hFFFF, 16'hFFFF, 1'b1, 2'd0, 16'hFFFF, 1'b1, 1'b0, 3'd0},
    '{16'h8000, 16'h8000, 1'b0, 2'd2, 16'h8000, 1'b1, 1'b1, 3'd0},
    '{16'h7FFF, 16'hFFFF, 1'b0, 2'd3, 16'h7FFF, 1'b0, 1'b1, 3'd3},
    '{16'h0010, 16'hFFF0, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 3'd2}
  };

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_cout", 32'(cout), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_skip", 32'(skip_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors, one at a time, with exact latency
    lat_mode = 1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
      wait_idle();
      check_val($sformatf("vec%0d_sum", i), 32'(last_sum), 32'(vecs[i].sum));
      check_val($sformatf("vec%0d_cout", i), 32'(last_cout), 32'(vecs[i].cout));
      check_val($sformatf("vec%0d_ovf", i), 32'(last_ovf), 32'(vecs[i].ovf));
      check_val($sformatf("vec%0d_skip", i), 32'(last_skip), 32'(vecs[i].skip));
    end

    // Back-pressure: 8 back-to-back ADDs, first result held 3 cycles
    lat_mode = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 2'd0);
      end
      begin
        for (int t = 0; t < 50; t++) begin
          @(posedge clk); #1;
          if (out_valid) break;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("bp_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset with three transactions in flight
    send(16'h1111, 16'h2222, 1'b0, 2'd0);
    send(16'h3333, 16'h4444, 1'b0, 2'd1);
    send(16'h5555, 16'h6666, 1'b1, 2'd2);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    check_val("midrst_sum", 32'(sum), 32'd0);
    check_val("midrst_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    lat_mode = 1;
    send(16'hABCD, 16'h1234, 1'b1, 2'd0);
    wait_idle();

    // Randomized ops with input gaps and random out_ready
    lat_mode = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
